// File: rtl/alt_vipvfr131_common_stream_arbiter.sv
// Frame-boundary arbiter: two Avalon-ST video sources share one registered output.
// Optional ARB_DROP_STATS_EN adds saturating per-source counters of discarded stray beats.
`timescale 1ns/1ps
module alt_vipvfr131_common_stream_arbiter #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in0_valid,
  output logic                  in0_ready,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic                  in0_sop,
  input  logic                  in0_eop,
  input  logic                  in1_valid,
  output logic                  in1_ready,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_sop,
  input  logic                  in1_eop,
  input  logic                  dout_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sop,
  output logic                  dout_eop,
  input  logic                  enable,
  output logic                  grant_src,
  output logic                  synced,
  output logic [15:0]           drop_cnt0,
  output logic [15:0]           drop_cnt1
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic                  rr_ptr, rr_nxt, grant_nxt, img_pkt, img_nxt, win;
  logic [1:0]            v, s, rdy, stray, req;
  logic [DATA_WIDTH-1:0] d_sel;
  logic                  sop_sel, eop_sel, acc, img_now;

  assign v   = {in1_valid, in0_valid};
  assign s   = {in1_sop, in0_sop};
  assign req = v & s;

  assign d_sel   = grant_src ? in1_data : in0_data;
  assign sop_sel = grant_src ? in1_sop  : in0_sop;
  assign eop_sel = grant_src ? in1_eop  : in0_eop;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      grant_src <= 1'b0;
      img_pkt   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      grant_src <= grant_nxt;
      img_pkt   <= img_nxt;
    end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant_src;
    img_nxt   = img_pkt;
    rdy       = '0;
    stray     = '0;
    acc       = 1'b0;
    win       = 1'b0;
    // a sop beat decides the packet type itself, so single-beat image packets end the frame
    img_now   = sop_sel ? (d_sel[3:0] == 4'd0) : img_pkt;
    case (state)
      IDLE: begin
        stray = rst ? 2'b00 : (v & ~s);
        rdy   = stray;
        if (enable && |req) begin
          win       = (&req) ? rr_ptr : req[1];
          grant_nxt = win;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        rdy[grant_src] = ~dout_valid | dout_ready;
        acc            = v[grant_src] & rdy[grant_src];
        if (acc) begin
          img_nxt = eop_sel ? 1'b0 : img_now;
          if (eop_sel && img_now) begin
            state_nxt = IDLE;
            rr_nxt    = ~grant_src;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in0_ready = rdy[0];
  assign in1_ready = rdy[1];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
    end else if (acc) begin
      dout_valid <= 1'b1;
      dout_data  <= d_sel;
      dout_sop   <= sop_sel;
      dout_eop   <= eop_sel;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end

  assign synced = (state == IDLE) && !dout_valid;

`ifdef ARB_DROP_STATS_EN
  logic [1:0][15:0] drop_cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst) drop_cnt <= '0;
    else
      for (int i = 0; i < 2; i++)
        if (stray[i] && drop_cnt[i] != 16'hFFFF) drop_cnt[i] <= drop_cnt[i] + 16'd1;

  assign drop_cnt0 = drop_cnt[0];
  assign drop_cnt1 = drop_cnt[1];
`else
  assign drop_cnt0 = 16'd0;
  assign drop_cnt1 = 16'd0;
`endif
endmodule

// File: tb/tb_alt_vipvfr131_common_stream_arbiter.sv
// Scoreboard bench for the two-source frame arbiter: expected beats are queued per test, popped at output.
`timescale 1ns/1ps
module tb_alt_vipvfr131_common_stream_arbiter;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    iv, is, ie;
  logic [DW-1:0] id [2];
  logic          dout_ready, enable;
  logic          in0_ready, in1_ready, dout_valid, dout_sop, dout_eop, grant_src, synced;
  logic [DW-1:0] dout_data;
  logic [15:0]   drop_cnt0, drop_cnt1;

  always #5 clk = ~clk;

  alt_vipvfr131_common_stream_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(iv[0]), .in0_ready(in0_ready), .in0_data(id[0]), .in0_sop(is[0]), .in0_eop(ie[0]),
    .in1_valid(iv[1]), .in1_ready(in1_ready), .in1_data(id[1]), .in1_sop(is[1]), .in1_eop(ie[1]),
    .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_data(dout_data),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .enable(enable),
    .grant_src(grant_src), .synced(synced), .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic [DW-1:0] d; logic s; logic e;} beat_t;
  beat_t exp_q[$];

  function automatic logic [DW-1:0] bdata(input int tag, input int typ, input int i);
    return DW'(tag * 16 + ((i == 0) ? typ : (i & 15)));
  endfunction

  task automatic push_pkt(input int tag, input int typ, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({bdata(tag, typ, i), i == 0, i == n - 1});
  endtask

  // drive one packet on a source, one beat per handshake; sopflag=0 sends headerless strays
  task automatic send(input int src, input int tag, input int typ, input int n, input bit sopflag);
    for (int i = 0; i < n; i++) begin
      int t;
      iv[src] = 1'b1;
      is[src] = sopflag && (i == 0);
      ie[src] = sopflag && (i == n - 1);
      id[src] = bdata(tag, typ, i);
      t = 0;
      @(negedge clk);
      while (!((src == 0) ? in0_ready : in1_ready) && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        chk("handshake_timeout", 32'd0, 32'd1);
        iv[src] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    iv[src] = 1'b0; is[src] = 1'b0; ie[src] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iv = '0; is = '0; ie = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // output monitor: scoreboard pop, stall stability, optional 1-cycle latency check
  logic          mon_en = 1'b0, lat_en = 1'b0;
  logic          pv = 1'b0, pr = 1'b0, acc_prev = 1'b0;
  logic [DW+2:0] pbeat = '0;
  logic [DW-1:0] acc_d = '0;
  int            stall_seen = 0;
  beat_t         e;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (lat_en && acc_prev) begin
        chk("lat_valid", 32'(dout_valid), 32'd1);
        chk("lat_data", 32'(dout_data), 32'(acc_d));
      end
      if (pv && !pr) begin
        stall_seen <= stall_seen + 1;
        chk("stall_hold", 32'({dout_valid, dout_data, dout_sop, dout_eop}), 32'(pbeat));
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 32'({dout_data, dout_sop, dout_eop}), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("beat", 32'({dout_data, dout_sop, dout_eop}), 32'(e));
        end
      end
    end
    pv       <= rst ? 1'b0 : dout_valid;
    pr       <= dout_ready;
    pbeat    <= {dout_valid, dout_data, dout_sop, dout_eop};
    acc_prev <= (iv[0] & in0_ready) | (iv[1] & in1_ready);
    acc_d    <= in1_ready ? id[1] : id[0];
  end

  initial begin
    logic [15:0] exp_drop;
    iv = '0; is = '0; ie = '0; id[0] = '0; id[1] = '0;
    dout_ready = 1'b1; enable = 1'b1;
    #2;
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout_data", 32'(dout_data), 32'd0);
    chk("rst_sop_eop", 32'({dout_sop, dout_eop}), 32'd0);
    chk("rst_ready", 32'({in1_ready, in0_ready}), 32'd0);
    chk("rst_grant", 32'(grant_src), 32'd0);
    chk("rst_synced", 32'(synced), 32'd1);
    chk("rst_drops", 32'({drop_cnt1, drop_cnt0}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // control packet then image packet on in0 alone
    push_pkt(1, 15, 3);
    push_pkt(2, 0, 8);
    lat_en = 1'b1;
    send(0, 1, 15, 3, 1'b1);
    send(0, 2, 0, 8, 1'b1);
    repeat (3) @(negedge clk);
    lat_en = 1'b0;
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_grant", 32'(grant_src), 32'd0);
    chk("t1_synced", 32'(synced), 32'd1);

    // simultaneous requests: in0, in1, then in0 again by round robin
    do_reset();
    push_pkt(3, 0, 4);
    push_pkt(4, 0, 4);
    fork send(0, 3, 0, 4, 1'b1); send(1, 4, 0, 4, 1'b1); join
    chk("t2_grant_in1", 32'(grant_src), 32'd1);
    push_pkt(5, 0, 2);
    push_pkt(6, 0, 1);
    fork send(0, 5, 0, 2, 1'b1); send(1, 6, 0, 1, 1'b1); join
    repeat (3) @(negedge clk);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // downstream backpressure 1,0,0,1 mid-frame
    do_reset();
    push_pkt(7, 0, 6);
    fork
      send(0, 7, 0, 6, 1'b1);
      begin
        repeat (4) @(posedge clk);
        #1 dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 dout_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("t3_stalled", 32'(stall_seen >= 2), 32'd1);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // enable drops mid in1 frame; in0 sop must wait until re-enabled
    do_reset();
    push_pkt(8, 0, 6);
    fork
      send(1, 8, 0, 6, 1'b1);
      begin repeat (4) @(posedge clk); #1 enable = 1'b0; end
    join
    chk("t4_grant_in1", 32'(grant_src), 32'd1);
    push_pkt(9, 0, 3);
    fork
      send(0, 9, 0, 3, 1'b1);
      begin
        repeat (10) @(negedge clk);
        chk("t4_in0_held", 32'(in0_ready), 32'd0);
        chk("t4_no_out", 32'(dout_valid), 32'd0);
        chk("t4_synced", 32'(synced), 32'd1);
        @(posedge clk); #1 enable = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // stray non-sop beats on in1 while idle are discarded
    do_reset();
    send(1, 10, 0, 2, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_no_out", 32'(dout_valid), 32'd0);
`ifdef ARB_DROP_STATS_EN
    exp_drop = 16'd2;
`else
    exp_drop = 16'd0;
`endif
    chk("t5_drop1", 32'(drop_cnt1), 32'(exp_drop));
    chk("t5_drop0", 32'(drop_cnt0), 32'd0);

    // reset mid-frame, then fresh arbitration
    do_reset();
    push_pkt(11, 0, 3);
    send(0, 11, 0, 3, 1'b1);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    iv[1] = 1'b1; is[1] = 1'b1; id[1] = bdata(12, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_valid", 32'(dout_valid), 32'd1);
    chk("t6_pre_grant", 32'(grant_src), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(dout_valid), 32'd0);
    chk("t6_rst_ready", 32'(in1_ready), 32'd0);
    chk("t6_rst_grant", 32'(grant_src), 32'd0);
    chk("t6_rst_synced", 32'(synced), 32'd1);
    iv = '0; is = '0; ie = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    push_pkt(13, 0, 2);
    push_pkt(14, 0, 2);
    fork send(0, 13, 0, 2, 1'b1); send(1, 14, 0, 2, 1'b1); join

    repeat (5) @(negedge clk);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
